// File: rtl/mux4_scan_ctrl_pkg.sv
// Shared constants, state encoding and a bit-insert helper for the mux4 scan sequencer.
package mux4_scan_ctrl_pkg;

    // Mux data width and select width.
    localparam int unsigned DataW = 4;
    localparam int unsigned SelW  = 2;
    localparam int unsigned CntW  = 4;

    // Last select value; reaching it ends the scan instead of wrapping.
    localparam logic [SelW-1:0] SelLast = 2'd3;

    // Sequencer states with fixed encodings.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

    // Return data with bit idx replaced by val.
    function automatic logic [DataW-1:0] set_bit(
        input logic [DataW-1:0] data,
        input logic [SelW-1:0]  idx,
        input logic             val
    );
        logic [DataW-1:0] r;
        r      = data;
        r[idx] = val;
        return r;
    endfunction

endpackage

// File: rtl/multiplexer4to1.sv
// Plain combinational 4-to-1 multiplexer: out = i[s].
module multiplexer4to1 (
    input  logic [3:0] i,
    input  logic [1:0] s,
    output logic       out
);

    // Select one of the four data bits.
    always_comb begin
        out = i[s];
    end

endmodule

// File: rtl/mux4_scan_loop.sv
// Loopback wrapper: the scan sequencer driving a multiplexer4to1 and reading it back.
module mux4_scan_loop #(
    parameter int unsigned DWELL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       out_err
);

    logic [3:0] mux_i;
    logic [1:0] mux_s;
    logic       mux_out;

    mux4_scan_ctrl #(
        .DWELL (DWELL)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mux_i     (mux_i),
        .mux_s     (mux_s),
        .mux_out   (mux_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    multiplexer4to1 u_mux (
        .i   (mux_i),
        .s   (mux_s),
        .out (mux_out)
    );

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer: accepts a 4-bit word, drives it onto a 4-to-1 mux, walks the select
// lines 0..3, rebuilds the word from the mux output and reports it with a mismatch flag.
module mux4_scan_ctrl
    import mux4_scan_ctrl_pkg::*;
#(
    parameter int unsigned DWELL = 1  // cycles per select value, 1..15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DataW-1:0] in_data,
    output logic [DataW-1:0] mux_i,
    output logic [SelW-1:0]  mux_s,
    input  logic             mux_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DataW-1:0] out_data,
    output logic             out_err
);

    // Dwell count at which the current select value is sampled.
    localparam logic [CntW-1:0] DwellLast = CntW'(DWELL - 1);

    state_e           state_q,    state_d;
    logic [DataW-1:0] mux_i_q,    mux_i_d;
    logic [SelW-1:0]  mux_s_q,    mux_s_d;
    logic [DataW-1:0] cap_q,      cap_d;
    logic [CntW-1:0]  dwell_q,    dwell_d;
    logic [DataW-1:0] out_data_q, out_data_d;
    logic             out_err_q,  out_err_d;

    // Next-state and handshake logic; everything holds unless a state says otherwise.
    always_comb begin
        state_d    = state_q;
        mux_i_d    = mux_i_q;
        mux_s_d    = mux_s_q;
        cap_d      = cap_q;
        dwell_d    = dwell_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        in_ready   = 1'b0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mux_i_d = in_data;
                    cap_d   = '0;
                    mux_s_d = '0;
                    dwell_d = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (dwell_q == DwellLast) begin
                    dwell_d = '0;
                    cap_d   = set_bit(cap_q, mux_s_q, mux_out);
                    if (mux_s_q == SelLast) begin
                        // Result registers load once, so they stay stable throughout DONE.
                        out_data_d = cap_d;
                        out_err_d  = (cap_d != mux_i_q);
                        state_d    = StDone;
                    end else begin
                        mux_s_d = mux_s_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 4'd1;
                end
            end
            StDone: begin
                // in_valid is ignored here; the next accept waits for IDLE.
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mux_i_q    <= '0;
            mux_s_q    <= '0;
            cap_q      <= '0;
            dwell_q    <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mux_i_q    <= mux_i_d;
            mux_s_q    <= mux_s_d;
            cap_q      <= cap_d;
            dwell_q    <= dwell_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    // Output drive from registered state.
    always_comb begin
        mux_i     = mux_i_q;
        mux_s     = mux_s_q;
        out_valid = (state_q == StDone);
        out_data  = out_data_q;
        out_err   = out_err_q;
    end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Scoreboard bench: two sequencers (DWELL=1 and DWELL=3), each looped through a
// behavioural mux that can be forced stuck-at-0.
module tb_mux4_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic out_ready;

    logic       in_valid1, in_ready1, mux_out1, out_valid1, out_err1, stuck1;
    logic [3:0] in_data1, mux_i1, out_data1;
    logic [1:0] mux_s1;

    logic       in_valid3, in_ready3, mux_out3, out_valid3, out_err3, stuck3;
    logic [3:0] in_data3, mux_i3, out_data3;
    logic [1:0] mux_s3;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_ret1 = 0;
    int n_ret3 = 0;
    int prev_acc = -1;
    logic sweep_on = 1'b0;

    logic [4:0] q1[$];
    logic [4:0] q3[$];
    logic [4:0] e1, e3;
    logic [3:0] x1, x3;

    // Behavioural mux loopback, optionally stuck at 0.
    assign mux_out1 = stuck1 ? 1'b0 : mux_i1[mux_s1];
    assign mux_out3 = stuck3 ? 1'b0 : mux_i3[mux_s3];

    mux4_scan_ctrl #(.DWELL(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .mux_i     (mux_i1),
        .mux_s     (mux_s1),
        .mux_out   (mux_out1),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_data  (out_data1),
        .out_err   (out_err1)
    );

    mux4_scan_ctrl #(.DWELL(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .mux_i     (mux_i3),
        .mux_s     (mux_s3),
        .mux_out   (mux_out3),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .out_data  (out_data3),
        .out_err   (out_err3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // DUT1 scoreboard: push on accept, pop on retire (decided at negedge before the edge).
    always @(negedge clk) begin
        if (rst_n && in_valid1 && in_ready1) begin
            x1 = stuck1 ? 4'h0 : in_data1;
            q1.push_back({(x1 != in_data1), x1});
            if (sweep_on && prev_acc >= 0) chk("sweep_gap", cyc - prev_acc, 6);
            prev_acc = cyc;
        end
        if (rst_n && out_valid1 && out_ready) begin
            n_ret1++;
            chk("sb1_depth", q1.size(), 1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk("out_data1", out_data1, e1[3:0]);
                chk("out_err1", out_err1, e1[4]);
            end
        end
    end

    // DUT3 scoreboard.
    always @(negedge clk) begin
        if (rst_n && in_valid3 && in_ready3) begin
            x3 = stuck3 ? 4'h0 : in_data3;
            q3.push_back({(x3 != in_data3), x3});
        end
        if (rst_n && out_valid3 && out_ready) begin
            n_ret3++;
            chk("sb3_depth", q3.size(), 1);
            if (q3.size() > 0) begin
                e3 = q3.pop_front();
                chk("out_data3", out_data3, e3[3:0]);
                chk("out_err3", out_err3, e3[4]);
            end
        end
    end

    task automatic wait_idle1();
        int n = 0;
        while (!in_ready1 && n < 100) begin step(); n++; end
        chk("idle1_timeout", in_ready1, 1);
    endtask

    task automatic wait_done1();
        int n = 0;
        while (!out_valid1 && n < 100) begin step(); n++; end
        chk("done1_timeout", out_valid1, 1);
    endtask

    task automatic wait_idle3();
        int n = 0;
        while (!in_ready3 && n < 100) begin step(); n++; end
        chk("idle3_timeout", in_ready3, 1);
    endtask

    task automatic wait_done3();
        int n = 0;
        while (!out_valid3 && n < 100) begin step(); n++; end
        chk("done3_timeout", out_valid3, 1);
    endtask

    // Returns in the cycle after the accept edge.
    task automatic send1(input logic [3:0] d);
        wait_idle1();
        in_valid1 = 1'b1;
        in_data1  = d;
        step();
        in_valid1 = 1'b0;
    endtask

    task automatic send3(input logic [3:0] d);
        wait_idle3();
        in_valid3 = 1'b1;
        in_data3  = d;
        step();
        in_valid3 = 1'b0;
    endtask

    task automatic chk_reset1(input string tag);
        chk({tag, "_in_ready"}, in_ready1, 1);
        chk({tag, "_out_valid"}, out_valid1, 0);
        chk({tag, "_mux_s"}, mux_s1, 0);
        chk({tag, "_mux_i"}, mux_i1, 0);
        chk({tag, "_out_data"}, out_data1, 0);
        chk({tag, "_out_err"}, out_err1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid1 = 1'b1;
        in_data1  = 4'hF;
        in_valid3 = 1'b1;
        in_data3  = 4'hF;
        stuck1    = 1'b0;
        stuck3    = 1'b0;

        // Reset held with in_valid high: nothing may be accepted.
        repeat (2) begin
            step();
            chk_reset1("rst");
            chk("rst3_mux_i", mux_i3, 0);
        end
        in_valid1 = 1'b0;
        in_valid3 = 1'b0;
        rst_n     = 1'b1;
        step();
        chk("post_rst_ready", in_ready1, 1);

        // Loopback of 1010 with select stepping and 4-cycle latency.
        send1(4'b1010);
        for (int k = 0; k < 4; k++) begin
            chk("lb_sel", mux_s1, k);
            chk("lb_valid_early", out_valid1, 0);
            step();
        end
        chk("lb_valid_rise", out_valid1, 1);
        step();

        // All 16 words back-to-back; accepts must be 6 cycles apart.
        sweep_on = 1'b1;
        prev_acc = -1;
        for (int w = 0; w < 16; w++) begin
            wait_idle1();
            in_valid1 = 1'b1;
            in_data1  = 4'(w);
            step();
        end
        in_valid1 = 1'b0;
        wait_done1();
        step();
        sweep_on = 1'b0;

        // Backpressure: DONE held 5 cycles while a new word waits.
        out_ready = 1'b0;
        send1(4'h5);
        wait_done1();
        in_valid1 = 1'b1;
        in_data1  = 4'h9;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", out_valid1, 1);
            chk("bp_data", out_data1, 4'h5);
            chk("bp_in_ready", in_ready1, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_idle_after_retire", in_ready1, 1);
        step();
        chk("bp_accept_mux_i", mux_i1, 4'h9);
        chk("bp_scan_in_ready", in_ready1, 0);
        in_valid1 = 1'b0;
        wait_done1();
        step();

        // Stuck-at-0 mux with DWELL=1.
        stuck1 = 1'b1;
        send1(4'b0110);
        wait_done1();
        chk("fault_data", out_data1, 4'b0000);
        chk("fault_err", out_err1, 1);
        step();
        stuck1 = 1'b0;

        // Stuck-at-0 mux with DWELL=3: each select held 3 cycles.
        stuck3 = 1'b1;
        send3(4'b0110);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                chk("dw3_sel", mux_s3, k);
                chk("dw3_valid_early", out_valid3, 0);
                step();
            end
        end
        chk("dw3_valid_rise", out_valid3, 1);
        chk("dw3_err", out_err3, 1);
        step();
        stuck3 = 1'b0;
        send3(4'b1011);
        wait_done3();
        step();

        // Reset while mux_s is 2 abandons the word.
        send1(4'h7);
        chk("rms_sel0", mux_s1, 0);
        step();
        step();
        chk("rms_sel2", mux_s1, 2);
        rst_n = 1'b0;
        q1.delete();
        step();
        chk_reset1("rms");
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("rms_no_valid", out_valid1, 0);
            step();
        end
        send1(4'b0001);
        wait_done1();
        chk("rms_recover_data", out_data1, 4'b0001);
        step();

        chk("retired1", n_ret1, 21);
        chk("retired3", n_ret3, 2);
        chk("q1_empty", q1.size(), 0);
        chk("q3_empty", q3.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
